// File: rtl/johnson_pkg.sv
// Shared types and helpers for Johnson-code consumers: lock FSM state,
// default geometry and the Johnson successor function.
package johnson_pkg;

  localparam int unsigned JPT_DEF_WIDTH  = 8;
  localparam int unsigned JPT_DEF_PHASES = 2 * JPT_DEF_WIDTH;
  localparam int unsigned JPT_MAX_WIDTH  = 64;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } jpt_state_t;

  // Next Johnson word for a 'width'-bit counter held in the low bits of x.
  function automatic logic [JPT_MAX_WIDTH-1:0] succ(input logic [JPT_MAX_WIDTH-1:0] x,
                                                    input int unsigned width);
    logic [JPT_MAX_WIDTH-1:0] mask;
    mask = (width >= JPT_MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
    return {x[JPT_MAX_WIDTH-2:0], ~x[width-1]} & mask;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson-word checker/decoder: flags legal codes and maps them
// to a binary phase index in 0 .. 2*WIDTH-1.
module johnson_decode #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [PW-1:0]    phase
);

  localparam logic [PW:0] NUM_PHASES = (PW + 1)'(2 * WIDTH);

  logic [WIDTH-1:0] inv;
  logic [PW:0]      pop;
  logic [PW:0]      back;

  always_comb begin
    inv = ~code;
    // A low-aligned run of ones has no bit in common with itself plus one.
    if (code[WIDTH-1]) legal = ((inv  & (inv  + WIDTH'(1))) == '0);
    else               legal = ((code & (code + WIDTH'(1))) == '0);

    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + (PW + 1)'(code[i]);

    back  = NUM_PHASES - pop;
    phase = code[WIDTH-1] ? back[PW-1:0] : pop[PW-1:0];
  end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Johnson counter consumer: validates and decodes samples, tracks lock and
// counts completed cycles. Optional macro JPT_STALL_TOLERATE_EN accepts repeats.
module johnson_phase_tracker
  import johnson_pkg::*;
#(
  parameter int WIDTH      = JPT_DEF_WIDTH,
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 3,
  parameter int CNT_W      = 16,
  parameter int PW         = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             r,
  input  logic [WIDTH-1:0] jc_in,
  input  logic             jc_valid,
  output logic [PW-1:0]    phase,
  output logic             phase_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_cnt,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_COUNT);
  localparam logic [MW-1:0] MISS_TGT = MW'(MISS_LIMIT);

  jpt_state_t       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             phase_valid_q, phase_valid_d;
  logic             err_pulse_q, err_pulse_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
`ifdef JPT_STALL_TOLERATE_EN
  logic [WIDTH-1:0] prev_q, prev_d;
`endif

  logic                     dec_legal;
  logic [PW-1:0]            dec_phase;
  logic [JPT_MAX_WIDTH-1:0] succ_wide;
  logic [WIDTH-1:0]         succ_word;
  logic                     is_stall;
  logic [MW-1:0]            miss_inc;

  johnson_decode #(.WIDTH(WIDTH), .PW(PW)) u_decode (
    .code  (jc_in),
    .legal (dec_legal),
    .phase (dec_phase)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    good_cnt_d    = good_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    err_pulse_d   = 1'b0;
    err_cnt_d     = err_cnt_q;
    wrap_pulse_d  = 1'b0;
    cycle_cnt_d   = cycle_cnt_q;
    succ_wide     = succ(JPT_MAX_WIDTH'(jc_in), WIDTH);
    succ_word     = succ_wide[WIDTH-1:0];
    miss_inc      = miss_cnt_q + MW'(1);
    is_stall      = 1'b0;
`ifdef JPT_STALL_TOLERATE_EN
    prev_d   = prev_q;
    is_stall = (state_q == LOCKED) && dec_legal && (jc_in == prev_q);
`endif

    if (jc_valid) begin
      if (dec_legal) begin
        phase_d       = dec_phase;
        phase_valid_d = 1'b1;
`ifdef JPT_STALL_TOLERATE_EN
        prev_d        = jc_in;
`endif
      end

      case (state_q)
        SEARCH: begin
          if (!dec_legal) begin
            good_cnt_d = '0;
          end else begin
            exp_d = succ_word;
            if (jc_in == exp_q) begin
              good_cnt_d = good_cnt_q + GW'(1);
              if (good_cnt_d == LOCK_TGT) begin
                state_d    = LOCKED;
                miss_cnt_d = '0;
              end
            end else begin
              good_cnt_d = '0;
            end
          end
        end

        LOCKED: begin
          if (is_stall) begin
            // Upstream held its word; only the phase report refreshes.
          end else if (dec_legal && (jc_in == exp_q)) begin
            miss_cnt_d = '0;
            exp_d      = succ_word;
            if (dec_phase == '0) begin
              wrap_pulse_d = 1'b1;
              cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
            end
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            // A legal but unexpected word resynchronises the expectation.
            if (dec_legal) exp_d = succ_word;
            miss_cnt_d = miss_inc;
            if (miss_inc == MISS_TGT) begin
              state_d    = SEARCH;
              good_cnt_d = '0;
            end
          end
        end

        default: state_d = SEARCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (r) begin
      state_q       <= SEARCH;
      exp_q         <= '0;
      good_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_cnt_q     <= '0;
      wrap_pulse_q  <= 1'b0;
      cycle_cnt_q   <= '0;
`ifdef JPT_STALL_TOLERATE_EN
      prev_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      good_cnt_q    <= good_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      err_pulse_q   <= err_pulse_d;
      err_cnt_q     <= err_cnt_d;
      wrap_pulse_q  <= wrap_pulse_d;
      cycle_cnt_q   <= cycle_cnt_d;
`ifdef JPT_STALL_TOLERATE_EN
      prev_q        <= prev_d;
`endif
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign locked      = (state_q == LOCKED);
  assign err_pulse   = err_pulse_q;
  assign err_cnt     = err_cnt_q;
  assign wrap_pulse  = wrap_pulse_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Directed self-checking bench for johnson_phase_tracker (WIDTH=8 defaults);
// expectations follow JPT_STALL_TOLERATE_EN when it is defined.
module tb_johnson_phase_tracker;

  logic        clk = 1'b0;
  logic        r;
  logic [7:0]  jc_in;
  logic        jc_valid;
  logic [3:0]  phase;
  logic        phase_valid;
  logic        locked;
  logic        err_pulse;
  logic [7:0]  err_cnt;
  logic        wrap_pulse;
  logic [15:0] cycle_cnt;

  int         n_cmp  = 0;
  int         n_fail = 0;
  int         wraps;
  logic [7:0] e_err;
  logic [7:0] jseq [16];

  johnson_phase_tracker dut (
    .clk         (clk),
    .r           (r),
    .jc_in       (jc_in),
    .jc_valid    (jc_valid),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_cnt     (err_cnt),
    .wrap_pulse  (wrap_pulse),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] ph, input logic pv,
                           input logic lk, input logic ep, input logic [7:0] ec,
                           input logic wp, input logic [15:0] cc);
    chk({tag, ".phase"},       32'(phase),       32'(ph));
    chk({tag, ".phase_valid"}, 32'(phase_valid), 32'(pv));
    chk({tag, ".locked"},      32'(locked),      32'(lk));
    chk({tag, ".err_pulse"},   32'(err_pulse),   32'(ep));
    chk({tag, ".err_cnt"},     32'(err_cnt),     32'(ec));
    chk({tag, ".wrap_pulse"},  32'(wrap_pulse),  32'(wp));
    chk({tag, ".cycle_cnt"},   32'(cycle_cnt),   32'(cc));
  endtask

  // Drive on the falling edge, then look #1 after the rising edge.
  task automatic step(input logic [7:0] w, input logic v);
    @(negedge clk);
    jc_in    = w;
    jc_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Reset with a valid sample present to show reset wins.
  task automatic pulse_reset();
    @(negedge clk);
    r        = 1'b1;
    jc_valid = 1'b1;
    jc_in    = 8'h07;
    @(posedge clk);
    #1;
    check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 16'd0);
    @(negedge clk);
    r        = 1'b0;
    jc_valid = 1'b0;
  endtask

  initial begin
    jseq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
             8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    r = 1'b1; jc_valid = 1'b0; jc_in = 8'h00;
    e_err = 8'd0;
    repeat (2) @(posedge clk);
    pulse_reset();

    // Acquire lock on a clean run from 00 (reset expectation is 00).
    step(8'h00, 1'b1);
    step(8'h01, 1'b1);
    step(8'h03, 1'b1);
    chk("acq.not_yet_locked", 32'(locked), 32'd0);
    step(8'h07, 1'b1);
    chk("acq.locked_at_07", 32'(locked), 32'd1);
    step(8'h0F, 1'b1);
    check_all("acq.0F", 4'd4, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 16'd0);

    // Illegal word while locked: error, phase held; next correct word is clean.
    step(8'h5A, 1'b1);
    e_err = e_err + 8'd1;
    check_all("illegal.5A", 4'd4, 1'b0, 1'b1, 1'b1, e_err, 1'b0, 16'd0);
    step(8'h1F, 1'b1);
    check_all("illegal.1F", 4'd5, 1'b1, 1'b1, 1'b0, e_err, 1'b0, 16'd0);

    // 32 clean samples from 3F: wraps at the two 80->00 steps.
    wraps = 0;
    for (int k = 6; k < 38; k++) begin
      step(jseq[k % 16], 1'b1);
      chk("clean.phase", 32'(phase), 32'(k % 16));
      chk("clean.wrap_pulse", 32'(wrap_pulse), 32'(k % 16 == 0));
      if (wrap_pulse) wraps++;
    end
    chk("clean.wrap_count", 32'(wraps), 32'd2);
    check_all("clean.end", 4'd5, 1'b1, 1'b1, 1'b0, e_err, 1'b0, 16'd2);

    // Repeated 3F while locked.
    step(8'h3F, 1'b1);
    check_all("stall.first", 4'd6, 1'b1, 1'b1, 1'b0, e_err, 1'b0, 16'd2);
    step(8'h3F, 1'b1);
`ifdef JPT_STALL_TOLERATE_EN
    check_all("stall.repeat", 4'd6, 1'b1, 1'b1, 1'b0, e_err, 1'b0, 16'd2);
`else
    e_err = e_err + 8'd1;
    check_all("stall.repeat", 4'd6, 1'b1, 1'b1, 1'b1, e_err, 1'b0, 16'd2);
`endif
    step(8'h7F, 1'b1);
    check_all("stall.after", 4'd7, 1'b1, 1'b1, 1'b0, e_err, 1'b0, 16'd2);

    // jc_valid low with garbage on the bus: nothing moves.
    for (int i = 0; i < 10; i++) begin
      step(8'h5A ^ 8'(i * 37), 1'b0);
      check_all("idle", 4'd7, 1'b0, 1'b1, 1'b0, e_err, 1'b0, 16'd2);
    end

    // Three consecutive illegal words drop lock on the third.
    step(8'h5A, 1'b1);
    e_err = e_err + 8'd1;
    check_all("miss.1", 4'd7, 1'b0, 1'b1, 1'b1, e_err, 1'b0, 16'd2);
    step(8'hA5, 1'b1);
    e_err = e_err + 8'd1;
    check_all("miss.2", 4'd7, 1'b0, 1'b1, 1'b1, e_err, 1'b0, 16'd2);
    step(8'h81, 1'b1);
    e_err = e_err + 8'd1;
    check_all("miss.3", 4'd7, 1'b0, 1'b0, 1'b1, e_err, 1'b0, 16'd2);

    // Expectation still FF: four correct successors relock.
    step(8'hFF, 1'b1);
    check_all("relock.FF", 4'd8, 1'b1, 1'b0, 1'b0, e_err, 1'b0, 16'd2);
    step(8'hFE, 1'b1);
    step(8'hFC, 1'b1);
    chk("relock.FC_unlocked", 32'(locked), 32'd0);
    step(8'hF8, 1'b1);
    check_all("relock.F8", 4'd11, 1'b1, 1'b1, 1'b0, e_err, 1'b0, 16'd2);

    // Mid-lock reset.
    pulse_reset();

    // Illegal word in SEARCH raises no error.
    step(8'h5A, 1'b1);
    check_all("search.illegal", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 16'd0);

    // Lock achieved on phase 0 is not a wrap.
    step(8'hF0, 1'b1);
    step(8'hE0, 1'b1);
    step(8'hC0, 1'b1);
    step(8'h80, 1'b1);
    chk("lock0.80_unlocked", 32'(locked), 32'd0);
    step(8'h00, 1'b1);
    check_all("lock0.00", 4'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 16'd0);
    step(8'h01, 1'b1);
    check_all("lock0.01", 4'd1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/johnson_phase_tracker.md
Name: johnson_phase_tracker

Overview:
Consumer stage placed directly downstream of the 8-bit Johnson ring counter. Samples the counter's output word, checks that it is one of the 2*WIDTH legal Johnson codes, and decodes it to a binary phase index. Runs a lock state machine that verifies each sample is the legal successor of the previous one. Reports lock status, sequence errors and completed-cycle counts to status logic.

Parameters:
WIDTH, 8, Johnson word width; legal phases = 2*WIDTH, phase index width PW = $clog2(2*WIDTH).
LOCK_COUNT, 4, consecutive correct successors required to enter LOCKED (>=1).
MISS_LIMIT, 3, consecutive bad samples in LOCKED that force a return to SEARCH (>=1).
CNT_W, 16, width of the completed-cycle counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
r  input  1  reset; synchronous, active-high.
jc_in  input  WIDTH  Johnson word from the upstream counter.
jc_valid  input  1  jc_in is a new sample this cycle; ignored otherwise.
phase  output  PW  decoded phase index of the last legal sample.
phase_valid  output  1  one-cycle pulse: phase updated from a legal sample.
locked  output  1  high while the FSM is in LOCKED.
err_pulse  output  1  one-cycle pulse on an illegal code or wrong successor while LOCKED.
err_cnt  output  8  error count, saturates at 255.
wrap_pulse  output  1  one-cycle pulse on a phase step 2*WIDTH-1 -> 0 while LOCKED.
cycle_cnt  output  CNT_W  completed-cycle count, wraps modulo 2^CNT_W.

Behaviour:
- Successor rule: succ(x) = {x[WIDTH-2:0], ~x[WIDTH-1]}. For WIDTH=8 the sequence is 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80, then 00.
- Legal code rules:
  - MSB=0: ones contiguous from bit 0 (includes all-zero).
  - MSB=1: ones contiguous from the MSB.
- Decode of a legal code, with p = popcount:
  - MSB=0 -> phase = p.
  - MSB=1 -> phase = (2*WIDTH - p) mod 2*WIDTH.
  - Examples: FF -> 8, FE -> 9, 80 -> 15.
- Timing: all outputs are registered. The response to a sample accepted at edge N is visible after edge N (one-cycle latency). Pulses last exactly one cycle. Nothing changes when jc_valid=0.
- FSM states are SEARCH and LOCKED, plus internal registers exp (expected next code), good_cnt and miss_cnt.
  - SEARCH, illegal sample: good_cnt <= 0. No err_pulse.
  - SEARCH, legal sample equal to exp: good_cnt++. Reaching LOCK_COUNT -> LOCKED, miss_cnt <= 0.
  - SEARCH, any other legal sample: good_cnt <= 0.
  - SEARCH, every legal sample: exp <= succ(sample).
  - LOCKED, sample == exp: miss_cnt <= 0, exp <= succ(sample).
  - LOCKED, legal sample != exp: err_pulse, miss_cnt++, exp <= succ(sample) (resynchronise).
  - LOCKED, illegal sample: err_pulse, miss_cnt++, exp unchanged.
  - LOCKED, miss_cnt reaching MISS_LIMIT: -> SEARCH, good_cnt <= 0. locked drops on the same edge as that error's err_pulse.
- phase and phase_valid update on every legal sample in both states. An illegal sample holds phase.
- wrap_pulse and cycle_cnt++ occur only in LOCKED, on a correct successor whose decoded phase is 0.
- Simultaneous events: a lock-achieving sample with phase 0 does not count as a wrap.
- Reset (r=1, including mid-sequence): state SEARCH; phase=0; all pulses 0; locked=0; err_cnt=0; cycle_cnt=0; good_cnt=0; miss_cnt=0; exp=0. Reset overrides jc_valid in the same cycle.

Optional Feature:
JPT_STALL_TOLERATE_EN
- Defined: in LOCKED, a legal sample equal to the previous accepted sample is a stall.
  - No error and no miss_cnt change; exp is unchanged.
  - phase_valid still pulses.
- Undefined: a repeated sample is a wrong successor and is handled as an error.

Decomposition:
- Package johnson_pkg holds:
  - state enum jpt_state_t {SEARCH, LOCKED};
  - function succ();
  - constants for the default width and phase count.
- Sub-module johnson_decode: combinational, jc_in -> {legal, phase}. It is instantiated once and is reusable by other Johnson consumers.

Test Plan:
- Reset, then a clean sequence 00,01,03,07,0F with jc_valid=1 -> locked=1 after the 5th sample's edge; phase=4; err_cnt=0.
- While locked, run 32 more clean samples -> two wrap_pulses; cycle_cnt=2; phase returns to 0 after each 80->00 step.
- While locked at 0F, inject 5A (illegal) -> err_pulse; err_cnt=1; phase holds 4. Then 1F -> no error, miss_cnt cleared.
- While locked, inject three consecutive illegal words -> err_cnt+=3; locked drops on the third edge. Then 4 correct successors -> relock.
- jc_valid=0 for 10 cycles with garbage on jc_in -> all outputs unchanged.
- Repeat sample 3F twice while locked:
  - with JPT_STALL_TOLERATE_EN -> no err_pulse;
  - without it -> err_pulse, err_cnt+1.
- Assert r mid-lock -> all outputs at reset values the next cycle.
